// File: rtl/fpu_pkg.sv
// Shared FIR FPU definitions: FP29i and FP16 field layouts, exponent biases
// and the FP16 special encodings used by the output stage.
package fpu_pkg;
  localparam int FP29_EXP_W  = 6;
  localparam int FP29_MAN_W  = 22;
  localparam int FP16_EXP_W  = 5;
  localparam int FP16_FRAC_W = 10;
  localparam int FP29_BIAS   = 31;
  localparam int FP16_BIAS   = 15;

  localparam logic [15:0] POS_INF = 16'h7C00;
  localparam logic [15:0] MAX_FIN = 16'h7BFF;

  typedef struct packed {
    logic                  sgn;
    logic [FP29_EXP_W-1:0] exp;
    logic [FP29_MAN_W-1:0] man;
  } fp29i_t;
endpackage

// File: rtl/lzd22.sv
// Combinational leading-zero counter for a 22-bit mantissa; 22 means all zero.
module lzd22 (
  input  logic [21:0] man,
  output logic [4:0]  lz
);
  always_comb begin
    lz = 5'd22;
    // Ascending scan so the most significant set bit is the last to win.
    for (int i = 0; i < 22; i++) begin
      if (man[i]) lz = 5'(21 - i);
    end
  end
endmodule

// File: rtl/fp29i_to_fp16_norm.sv
// FP29i -> IEEE FP16 output stage: register+LZD, normalize/denormalize,
// round-to-nearest-even and pack, as a 3-stage pipeline with one global enable.
module fp29i_to_fp16_norm
  import fpu_pkg::*;
#(
  parameter bit SAT_ON_OVF = 1'b0,
  parameter int IN_BIAS    = FP29_BIAS,
  parameter int OUT_BIAS   = FP16_BIAS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        din_valid,
  output logic        din_ready,
  input  logic        din_uni_y_sgn,
  input  logic [5:0]  din_uni_y_exp,
  input  logic [21:0] din_uni_y_man_dn,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic [15:0] dout_fp16,
  output logic        dout_ovf,
  output logic        dout_unf,
  output logic        dout_inx
);
  localparam logic signed [7:0] BIAS_DIFF = 8'(IN_BIAS - OUT_BIAS);

  // Handshake: a word moves on a rising edge when valid & ready are both high;
  // the whole pipe advances together only when the output slot is free or taken.
  logic en;
  assign en        = ~dout_valid | dout_ready;
  assign din_ready = en;

  // ---------------- S1: register input, count leading zeros
  logic   s1_valid;
  fp29i_t s1_in;
  logic [4:0] s1_lz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_in    <= '0;
    end else if (en) begin
      s1_valid <= din_valid;
      s1_in    <= {din_uni_y_sgn, din_uni_y_exp, din_uni_y_man_dn};
    end
  end

  lzd22 u_lzd (
    .man (s1_in.man),
    .lz  (s1_lz)
  );

  // ---------------- S2: normalize, denormalize with sticky
  logic signed [7:0] e16;
  logic signed [7:0] sub_sh;
  logic [21:0] nm;
  logic [45:0] wide;
  logic [21:0] n_man;
  logic [7:0]  n_exp;
  logic        n_sticky;

  always_comb begin
    e16      = $signed({2'b00, s1_in.exp}) - BIAS_DIFF - $signed({3'b000, s1_lz});
    nm       = s1_in.man << s1_lz;
    sub_sh   = 8'sd1 - e16;
    wide     = {nm, 24'b0} >> sub_sh;
    n_man    = nm;
    n_exp    = $unsigned(e16);
    n_sticky = 1'b0;
    if (e16 <= 8'sd0) begin
      n_exp = '0;
      if (sub_sh >= 8'sd24) begin
        n_man    = '0;
        n_sticky = |s1_in.man;
      end else begin
        n_man    = wide[45:24];
        n_sticky = |wide[23:0];
      end
    end
  end

  logic        s2_valid;
  logic        s2_sgn;
  logic        s2_zero;
  logic [7:0]  s2_exp;
  logic [21:0] s2_man;
  logic        s2_sticky;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid  <= 1'b0;
      s2_sgn    <= 1'b0;
      s2_zero   <= 1'b0;
      s2_exp    <= '0;
      s2_man    <= '0;
      s2_sticky <= 1'b0;
    end else if (en) begin
      s2_valid  <= s1_valid;
      s2_sgn    <= s1_in.sgn;
      s2_zero   <= (s1_lz == 5'd22);
      s2_exp    <= n_exp;
      s2_man    <= n_man;
      s2_sticky <= n_sticky;
    end
  end

  // ---------------- S3: round to nearest even, pack, flags
  logic [FP16_FRAC_W-1:0] frac;
  logic        guard;
  logic        sticky;
  logic        rnd_up;
  logic        inx;
  logic [17:0] sum;
  logic [7:0]  e_fin;
  logic [15:0] ovf_word;
  logic [15:0] n_fp16;
  logic        n_ovf;
  logic        n_unf;
  logic        n_inx;

  assign ovf_word = SAT_ON_OVF ? MAX_FIN : POS_INF;

  always_comb begin
    frac   = s2_man[20:11];
    guard  = s2_man[10];
    sticky = (|s2_man[9:0]) | s2_sticky;
    rnd_up = guard & (sticky | frac[0]);
    inx    = guard | sticky;
    // Exponent and fraction added as one word so a fraction carry bumps the exponent.
    sum    = {s2_exp, frac} + {17'b0, rnd_up};
    e_fin  = sum[17:10];
    n_fp16 = {s2_sgn, e_fin[4:0], sum[9:0]};
    n_ovf  = 1'b0;
    n_inx  = inx;
    // Hidden bit clear on a nonzero value means the pre-round exponent field is 0.
    n_unf  = inx & ~s2_man[21];
    if (s2_zero) begin
      n_fp16 = {s2_sgn, 15'b0};
      n_inx  = 1'b0;
      n_unf  = 1'b0;
    end else if (e_fin >= 8'd31) begin
      n_fp16 = {s2_sgn, ovf_word[14:0]};
      n_ovf  = 1'b1;
      n_inx  = 1'b1;
      n_unf  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_valid <= 1'b0;
      dout_fp16  <= '0;
      dout_ovf   <= 1'b0;
      dout_unf   <= 1'b0;
      dout_inx   <= 1'b0;
    end else if (en) begin
      dout_valid <= s2_valid;
      dout_fp16  <= n_fp16;
      dout_ovf   <= n_ovf;
      dout_unf   <= n_unf;
      dout_inx   <= n_inx;
    end
  end
endmodule

// File: tb/tb_fp29i_to_fp16_norm.sv
// Directed bench for fp29i_to_fp16_norm: two instances (Inf and saturating
// overflow) share stimulus; a negedge monitor scores outputs against exp_q.
module tb_fp29i_to_fp16_norm;
  localparam int W = 38;  // {fp16,ovf,unf,inx} for Inf variant, then for sat variant

  // ---------------- clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  logic        din_valid, din_ready, din_ready_s;
  logic        din_uni_y_sgn;
  logic [5:0]  din_uni_y_exp;
  logic [21:0] din_uni_y_man_dn;
  logic        dout_ready;
  logic        dout_valid, dout_ovf, dout_unf, dout_inx;
  logic [15:0] dout_fp16;
  logic        dout_valid_s, dout_ovf_s, dout_unf_s, dout_inx_s;
  logic [15:0] dout_fp16_s;

  fp29i_to_fp16_norm #(.SAT_ON_OVF(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .din_valid(din_valid), .din_ready(din_ready),
    .din_uni_y_sgn(din_uni_y_sgn), .din_uni_y_exp(din_uni_y_exp),
    .din_uni_y_man_dn(din_uni_y_man_dn),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_fp16(dout_fp16),
    .dout_ovf(dout_ovf), .dout_unf(dout_unf), .dout_inx(dout_inx)
  );

  fp29i_to_fp16_norm #(.SAT_ON_OVF(1'b1)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .din_valid(din_valid), .din_ready(din_ready_s),
    .din_uni_y_sgn(din_uni_y_sgn), .din_uni_y_exp(din_uni_y_exp),
    .din_uni_y_man_dn(din_uni_y_man_dn),
    .dout_valid(dout_valid_s), .dout_ready(dout_ready), .dout_fp16(dout_fp16_s),
    .dout_ovf(dout_ovf_s), .dout_unf(dout_unf_s), .dout_inx(dout_inx_s)
  );

  // ---------------- scoreboard state
  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  int           cyc_q[$];
  bit           lat_q[$];
  bit           lat_on = 1'b1;
  int           n_cmp  = 0;
  int           n_err  = 0;
  bit           hold_on = 1'b0;
  logic [18:0]  hold_val;
  logic [W-1:0] mon_x;
  string        mon_t;
  int           mon_c;
  bit           mon_l;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic push_exp(input logic [18:0] x0, input logic [18:0] x1, input string tag);
    exp_q.push_back({x0, x1});
    tag_q.push_back(tag);
    cyc_q.push_back(cyc);
    lat_q.push_back(lat_on);
  endtask

  // ---------------- driver
  task automatic send(input logic s, input logic [5:0] e, input logic [21:0] m,
                      input logic [18:0] x0, input logic [18:0] x1, input string tag);
    int tries = 0;
    din_valid        = 1'b1;
    din_uni_y_sgn    = s;
    din_uni_y_exp    = e;
    din_uni_y_man_dn = m;
    #1;
    while (!din_ready && tries < 20) begin
      @(negedge clk);
      #1;
      tries++;
    end
    if (!din_ready) check({tag, "_accept_timeout"}, 32'd0, 32'd1);
    else push_exp(x0, x1, tag);
    @(negedge clk);
    din_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 32'd0);
    @(negedge clk);
  endtask

  // ---------------- monitor: sample mid low phase, well away from the rising edge
  always @(negedge clk) begin
    #3;
    if (rst_n) begin
      if (hold_on)
        check("stall_hold", {13'b0, dout_valid, dout_fp16, dout_ovf, dout_unf, dout_inx},
                            {13'b0, 1'b1, hold_val});
      hold_on  = dout_valid && !dout_ready;
      hold_val = {dout_fp16, dout_ovf, dout_unf, dout_inx};
      if (dout_valid && dout_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 32'd1, 32'd0);
        end else begin
          mon_x = exp_q.pop_front();
          mon_t = tag_q.pop_front();
          mon_c = cyc_q.pop_front();
          mon_l = lat_q.pop_front();
          check({mon_t, "_fp16"}, dout_fp16, mon_x[37:22]);
          check({mon_t, "_flags"}, {dout_ovf, dout_unf, dout_inx}, mon_x[21:19]);
          check({mon_t, "_sat_vld"}, dout_valid_s, 32'd1);
          check({mon_t, "_sat_fp16"}, dout_fp16_s, mon_x[18:3]);
          check({mon_t, "_sat_flags"}, {dout_ovf_s, dout_unf_s, dout_inx_s}, mon_x[2:0]);
          if (mon_l) check({mon_t, "_latency"}, cyc - mon_c, 32'd3);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus
  initial begin
    int k;
    int t;
    bit saw_stall;
    din_valid        = 1'b0;
    din_uni_y_sgn    = 1'b0;
    din_uni_y_exp    = '0;
    din_uni_y_man_dn = '0;
    dout_ready       = 1'b1;

    repeat (3) @(negedge clk);
    #1;
    check("rst_dout_valid", dout_valid, 32'd0);
    check("rst_dout_fp16", dout_fp16, 32'd0);
    check("rst_flags", {dout_ovf, dout_unf, dout_inx}, 32'd0);
    check("rst_din_ready", din_ready, 32'd1);
    check("rst_sat_fp16", dout_fp16_s, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // {fp16, ovf, unf, inx}: Inf variant, saturating variant
    send(0, 6'd31, 22'h200000, {16'h3C00, 3'b000}, {16'h3C00, 3'b000}, "one");
    send(0, 6'd31, 22'h100000, {16'h3800, 3'b000}, {16'h3800, 3'b000}, "half");
    send(0, 6'd31, 22'h200400, {16'h3C00, 3'b001}, {16'h3C00, 3'b001}, "tie_even");
    send(0, 6'd31, 22'h200C00, {16'h3C02, 3'b001}, {16'h3C02, 3'b001}, "tie_odd");
    send(0, 6'd31, 22'h200401, {16'h3C01, 3'b001}, {16'h3C01, 3'b001}, "above_tie");
    send(1, 6'd30, 22'h300000, {16'hBA00, 3'b000}, {16'hBA00, 3'b000}, "neg_0p75");
    send(0, 6'd46, 22'h3FF800, {16'h7BFF, 3'b000}, {16'h7BFF, 3'b000}, "max_fin");
    send(0, 6'd47, 22'h200000, {16'h7C00, 3'b101}, {16'h7BFF, 3'b101}, "ovf_e31");
    send(0, 6'd63, 22'h200000, {16'h7C00, 3'b101}, {16'h7BFF, 3'b101}, "ovf_e63");
    send(0, 6'd46, 22'h3FFFFF, {16'h7C00, 3'b101}, {16'h7BFF, 3'b101}, "ovf_carry");
    send(1, 6'd63, 22'h200000, {16'hFC00, 3'b101}, {16'hFBFF, 3'b101}, "ovf_neg");
    send(0, 6'd16, 22'h200000, {16'h0200, 3'b000}, {16'h0200, 3'b000}, "subn");
    send(0, 6'd16, 22'h3FFFFF, {16'h0400, 3'b011}, {16'h0400, 3'b011}, "subn_promote");
    send(1, 6'd16, 22'h000000, {16'h8000, 3'b000}, {16'h8000, 3'b000}, "neg_zero");
    send(0, 6'd0,  22'h000001, {16'h0000, 3'b011}, {16'h0000, 3'b011}, "tiny_unf");
    wait_drain();

    // Back-to-back stream with a 4-cycle output stall in the middle.
    lat_on    = 1'b0;
    saw_stall = 1'b0;
    k = 0;
    t = 0;
    while (k < 6 && t < 40) begin
      dout_ready       = !(t >= 3 && t < 7);
      din_valid        = 1'b1;
      din_uni_y_sgn    = 1'b0;
      din_uni_y_exp    = 6'd31;
      din_uni_y_man_dn = 22'h200000 + 22'(k << 11);
      #1;
      if (!din_ready) saw_stall = 1'b1;
      if (din_ready) begin
        push_exp({16'h3C00 + 16'(k), 3'b000}, {16'h3C00 + 16'(k), 3'b000}, $sformatf("bp%0d", k));
        k++;
      end
      @(negedge clk);
      t++;
    end
    din_valid  = 1'b0;
    dout_ready = 1'b1;
    check("bp_din_ready_dropped", saw_stall, 32'd1);
    check("bp_all_accepted", k, 32'd6);
    wait_drain();

    // Asynchronous reset with three words in flight.
    lat_on = 1'b1;
    send(0, 6'd31, 22'h280000, {16'h3D00, 3'b000}, {16'h3D00, 3'b000}, "lost0");
    send(0, 6'd31, 22'h300000, {16'h3E00, 3'b000}, {16'h3E00, 3'b000}, "lost1");
    send(0, 6'd31, 22'h380000, {16'h3F00, 3'b000}, {16'h3F00, 3'b000}, "lost2");
    #1;
    check("pre_rst_valid", dout_valid, 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_dout_valid", dout_valid, 32'd0);
    check("midrst_dout_fp16", dout_fp16, 32'd0);
    check("midrst_flags", {dout_ovf, dout_unf, dout_inx}, 32'd0);
    exp_q.delete();
    tag_q.delete();
    cyc_q.delete();
    lat_q.delete();
    hold_on = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("post_rst_idle", dout_valid, 32'd0);
    @(negedge clk);
    send(0, 6'd32, 22'h200000, {16'h4000, 3'b000}, {16'h4000, 3'b000}, "after_rst");
    wait_drain();

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
